// File: rtl/rk_cache_if.sv
// rk_cache_if: bundles the round-key cache's fill, replay and status signals.
//   slave  modport - cache side (rk_cache)
//   master modport - producer/consumer side (expander, cipher datapath, bench)
// Fill : fill_start, fill_enc, rk_vld, rk -> ; <- rk_rdy
// Play : rd_start, rd_dec, o_rdy -> ; <- o_vld, o_rk, o_idx, o_last
// State: <- cache_vld
interface rk_cache_if #(
    parameter int W = 128
);
    logic         fill_start;
    logic         fill_enc;
    logic         rk_vld;
    logic [W-1:0] rk;
    logic         rk_rdy;
    logic         rd_start;
    logic         rd_dec;
    logic         o_vld;
    logic [W-1:0] o_rk;
    logic [3:0]   o_idx;
    logic         o_last;
    logic         o_rdy;
    logic         cache_vld;

    modport slave (
        input  fill_start, fill_enc, rk_vld, rk, rd_start, rd_dec, o_rdy,
        output rk_rdy, o_vld, o_rk, o_idx, o_last, cache_vld
    );

    modport master (
        output fill_start, fill_enc, rk_vld, rk, rd_start, rd_dec, o_rdy,
        input  rk_rdy, o_vld, o_rk, o_idx, o_last, cache_vld
    );
endinterface

// File: rtl/rk_cache.sv
// rk_cache: stores one AES-128 schedule of NRK round keys, indexed by round
// number, and replays it forward (rk0..rk10) or reverse (rk10..rk0).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - rk_cache_if.slave: fill stream in, replay stream out, cache_vld
module rk_cache #(
    parameter int NRK = 11,
    parameter int W   = 128
) (
    input  logic        clk,
    input  logic        rst,
    rk_cache_if.slave   bus
);
    localparam logic [3:0] LAST = 4'(NRK - 1);

    typedef enum logic [1:0] {IDLE, FILL, READY, PLAY} state_t;

    state_t       r_state, w_next;
    logic [W-1:0] r_mem [NRK];
    logic [3:0]   r_wr_cnt, r_rd_cnt;
    logic         r_fill_enc, r_rd_dec;
    logic [W-1:0] r_o_rk;
    logic [3:0]   r_o_idx;
    logic         r_o_last;

    logic         w_wr_acc, w_rd_go, w_rd_acc, w_rd_adv;
    logic [3:0]   w_wr_idx, w_rd_cnt_nxt, w_rd_idx_nxt;
    logic         w_rd_dec_nxt;

    // fill_start overrides everything else in the same cycle: any beat or
    // rd_start presented alongside it is dropped.
    always_comb begin
        w_next   = r_state;
        w_wr_acc = 1'b0;
        w_rd_go  = 1'b0;
        w_rd_acc = 1'b0;
        if (bus.fill_start) begin
            w_next = FILL;
        end else begin
            case (r_state)
                IDLE: ;
                FILL: begin
                    if (bus.rk_vld) begin
                        w_wr_acc = 1'b1;
                        if (r_wr_cnt == LAST) w_next = READY;
                    end
                end
                READY: begin
                    if (bus.rd_start) begin
                        w_rd_go = 1'b1;
                        w_next  = PLAY;
                    end
                end
                PLAY: begin
                    if (bus.o_rdy) begin
                        w_rd_acc = 1'b1;
                        if (r_o_last) w_next = READY;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Next replay beat is computed one cycle ahead so o_rk/o_idx are registered.
    always_comb begin
        w_rd_adv     = w_rd_go | (w_rd_acc & ~r_o_last);
        w_rd_cnt_nxt = w_rd_go ? '0 : r_rd_cnt + 4'd1;
        w_rd_dec_nxt = w_rd_go ? bus.rd_dec : r_rd_dec;
        w_rd_idx_nxt = w_rd_dec_nxt ? LAST - w_rd_cnt_nxt : w_rd_cnt_nxt;
        w_wr_idx     = r_fill_enc ? r_wr_cnt : LAST - r_wr_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_fill_enc <= 1'b0;
            r_rd_dec   <= 1'b0;
            r_o_rk     <= '0;
            r_o_idx    <= '0;
            r_o_last   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (bus.fill_start) begin
                r_wr_cnt   <= '0;
                r_fill_enc <= bus.fill_enc;
                r_o_last   <= 1'b0;
            end else if (w_wr_acc) begin
                r_wr_cnt <= (r_wr_cnt == LAST) ? '0 : r_wr_cnt + 4'd1;
            end
            if (w_rd_adv) begin
                r_rd_cnt <= w_rd_cnt_nxt;
                r_rd_dec <= w_rd_dec_nxt;
                r_o_idx  <= w_rd_idx_nxt;
                r_o_rk   <= r_mem[w_rd_idx_nxt];
                r_o_last <= (w_rd_cnt_nxt == LAST);
            end else if (w_rd_acc) begin
                r_o_last <= 1'b0;
            end
        end
    end

    // Key storage carries no reset; cache_vld qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[w_wr_idx] <= bus.rk;
    end

    assign bus.rk_rdy    = (r_state == FILL);
    assign bus.o_vld     = (r_state == PLAY);
    assign bus.cache_vld = (r_state == READY) || (r_state == PLAY);
    assign bus.o_rk      = r_o_rk;
    assign bus.o_idx     = r_o_idx;
    assign bus.o_last    = r_o_last;
endmodule
